sha256_chain_ctrl: RTL and testbench
====================================

Name: sha256_chain_ctrl

Overview:
Multi-block SHA-256 sequencer that sits in front of the dassign2_1 compression core and accepts 512-bit padded message blocks over a valid/ready handshake. For each block it issues one core request and waits for the core's out_v. It chains each intermediate hash into the next request and emits the final digest with a one-cycle valid pulse. The initial hash value comes from H_startup. The controller never assumes a fixed core latency.

Parameters:
CNT_W, 8, width of the completed-block counter; the counter saturates at 2^CNT_W-1.
TIMEOUT, 128, core wait limit in cycles; used only when SHA_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
h_init  input  256  initial hash value, driven from H_startup
msg_blk  input  512  padded message block
msg_v  input  1  msg_blk is valid
msg_last  input  1  block is the final block of its message; qualified by msg_v
msg_rdy  output  1  controller can accept a block
abort  input  1  synchronous abort of the current message
core_H_in  output  256  chaining value to the core
core_M_in  output  512  block to the core
core_in_v  output  1  one-cycle request pulse to the core
core_H_out  input  256  core result
core_out_v  input  1  core result valid
digest  output  256  final hash value
digest_v  output  1  one-cycle digest-valid pulse
blk_cnt  output  CNT_W  number of blocks completed in the current or last message
busy  output  1  high whenever state is not IDLE
err  output  1  timeout error pulse (only with SHA_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, first=1, chain_reg=0.
  - core_H_in=0, core_M_in=0, core_in_v=0.
  - digest=0, digest_v=0, blk_cnt=0, err=0.
  - msg_rdy=1, busy=0.
  - An assertion mid-operation drops any in-flight block. No digest is produced, and a later core_out_v is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- msg_rdy = (state==IDLE), derived combinationally from the registered state. Acceptance happens on msg_v & msg_rdy.
- IDLE, on acceptance:
  - core_M_in<=msg_blk.
  - core_H_in<=(first ? h_init : chain_reg).
  - last_q<=msg_last.
  - If first, blk_cnt<=0.
  - first<=0, go to ISSUE.
- IDLE without acceptance: no change.
- ISSUE: core_in_v=1 for exactly this cycle, then go to WAIT. core_H_in and core_M_in stay stable until the next acceptance.
- WAIT, on core_out_v:
  - chain_reg<=core_H_out.
  - blk_cnt<=blk_cnt+1, saturating.
  - If last_q: digest<=core_H_out and go to DONE. Otherwise return to IDLE.
- DONE: digest_v=1 for exactly one cycle, first<=1, go to IDLE. digest holds its value until the next digest. blk_cnt holds until the next first block is accepted.
- core_out_v seen in IDLE, ISSUE or DONE: ignored.
- msg_v while msg_rdy=0: not accepted. The sender holds its data; no block is lost or duplicated.
- abort=1 in any state:
  - Next state IDLE, first<=1.
  - No digest_v; blk_cnt is unchanged.
  - abort has priority over acceptance and over core_out_v in the same cycle.
- Exactly one core_in_v pulse per accepted block. No new pulse until the previous core_out_v has been seen, or an abort or reset occurs.

Optional Feature:
SHA_TIMEOUT_EN.
- Defined: a wait counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT without core_out_v:
  - err=1 for one cycle.
  - Next state IDLE, first<=1, no digest.
  - core_out_v in that same cycle wins over the timeout.
- Undefined: err is tied to 0, there is no counter, and WAIT can last indefinitely.

Test Plan:
- Single block "abc" (6162638000…0018), h_init from H_startup, msg_last=1 -> exactly one core_in_v pulse. Then one digest_v pulse with digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and blk_cnt=1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with msg_last=0 then 1 -> the second core_H_in equals the first core_H_out. digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, blk_cnt=2, then a fresh "abc" message still yields the ba7816bf… digest.
- msg_v held high continuously from ISSUE through WAIT -> msg_rdy=0 and no second acceptance. Block accepted only in IDLE; core_in_v pulse count equals block count.
- abort asserted in WAIT during the first of two blocks -> busy=0 next cycle and no digest_v. A following "abc" message produces the ba7816bf… digest, showing h_init is used, not the stale chain value.
- reset pulled low mid-WAIT, then core_out_v arrives -> all outputs at reset values and no digest_v.
- SHA_TIMEOUT_EN defined, TIMEOUT=16, core stub never asserts out_v -> err pulses 16 cycles after entering WAIT, then state IDLE with msg_rdy=1.

Source files
------------

// File: rtl/sha256_chain_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_chain_ctrl_if : message-side and core-side signals of the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sha256_chain_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [255:0]     h_init;
  logic [511:0]     msg_blk;
  logic             msg_v;
  logic             msg_last;
  logic             msg_rdy;
  logic             abort;
  logic [255:0]     core_H_in;
  logic [511:0]     core_M_in;
  logic             core_in_v;
  logic [255:0]     core_H_out;
  logic             core_out_v;
  logic [255:0]     digest;
  logic             digest_v;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy;
  logic             err;

  // Controller side.
  modport slave (
    input  h_init, msg_blk, msg_v, msg_last, abort, core_H_out, core_out_v,
    output msg_rdy, core_H_in, core_M_in, core_in_v, digest, digest_v,
           blk_cnt, busy, err
  );

  // Environment side: block source, compression core and digest sink.
  modport master (
    output h_init, msg_blk, msg_v, msg_last, abort, core_H_out, core_out_v,
    input  msg_rdy, core_H_in, core_M_in, core_in_v, digest, digest_v,
           blk_cnt, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/sha256_chain_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_chain_ctrl : multi-block SHA-256 chaining sequencer for one core.
// Optional core-wait timeout enabled by defining SHA_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_chain_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 128
) (
  input  wire logic              clk,
  input  wire logic              reset,
  sha256_chain_ctrl_if.slave     s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  state_t           r_state;
  logic             r_first;
  logic             r_last_q;
  logic [255:0]     r_chain;
  logic [255:0]     r_core_h;
  logic [511:0]     r_core_m;
  logic             r_core_in_v;
  logic [255:0]     r_digest;
  logic             r_digest_v;
  logic [CNT_W-1:0] r_blk_cnt;

`ifdef SHA_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_err;
  logic                w_timeout;

  // A result arriving in the final wait cycle still counts as a success.
  assign w_timeout = (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1)) && !s.core_out_v;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_first     <= 1'b1;
      r_last_q    <= 1'b0;
      r_chain     <= '0;
      r_core_h    <= '0;
      r_core_m    <= '0;
      r_core_in_v <= 1'b0;
      r_digest    <= '0;
      r_digest_v  <= 1'b0;
      r_blk_cnt   <= '0;
`ifdef SHA_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_core_in_v <= 1'b0;
      r_digest_v  <= 1'b0;
`ifdef SHA_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      if (s.abort) begin
        r_state <= IDLE;
        r_first <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (s.msg_v) begin
              r_core_m    <= s.msg_blk;
              r_core_h    <= r_first ? s.h_init : r_chain;
              r_last_q    <= s.msg_last;
              if (r_first) r_blk_cnt <= '0;
              r_first     <= 1'b0;
              r_core_in_v <= 1'b1;
              r_state     <= ISSUE;
            end
          end
          ISSUE: begin
`ifdef SHA_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
            r_state <= WAIT;
          end
          WAIT: begin
            if (s.core_out_v) begin
              r_chain <= s.core_H_out;
              if (r_blk_cnt != c_CNT_MAX) r_blk_cnt <= r_blk_cnt + CNT_W'(1);
              if (r_last_q) begin
                r_digest   <= s.core_H_out;
                r_digest_v <= 1'b1;
                r_state    <= DONE;
              end else begin
                r_state <= IDLE;
              end
`ifdef SHA_TIMEOUT_EN
            end else if (w_timeout) begin
              r_err   <= 1'b1;
              r_first <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
`endif
            end
          end
          DONE: begin
            r_first <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign s.msg_rdy   = (r_state == IDLE);
  assign s.busy      = (r_state != IDLE);
  assign s.core_H_in = r_core_h;
  assign s.core_M_in = r_core_m;
  assign s.core_in_v = r_core_in_v;
  assign s.digest    = r_digest;
  assign s.digest_v  = r_digest_v;
  assign s.blk_cnt   = r_blk_cnt;
`ifdef SHA_TIMEOUT_EN
  assign s.err       = r_err;
`else
  assign s.err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha256_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_chain_ctrl : vector table plus corner sequences against a
// behavioural SHA-256 core stub with a digest scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sha256_chain_ctrl;

  localparam int CNT_W = 8;
`ifdef SHA_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 128;
`endif

  localparam logic [255:0] IV       = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_2     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 64'h8000000000000000};
  localparam logic [511:0] BLK_2B    = {448'h0, 64'h1c0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    int                 nblk;
    logic [1:0][511:0]  blk;
    logic [255:0]       exp;
  } vec_t;

  typedef struct {
    logic [255:0]     dg;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sha256_chain_ctrl_if #(.CNT_W(CNT_W)) bus ();

  sha256_chain_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus.slave)
  );

  int           total = 0;
  int           bad   = 0;
  int           n_req = 0;
  int           n_dv  = 0;
  exp_t         sb [$];
  logic [255:0] req_h [$];
  logic [511:0] req_m [$];
  logic [255:0] res_h [$];
  logic         stub_en      = 1'b1;
  logic         stub_pending = 1'b0;
  int           stub_cnt     = 0;
  int           stub_lat     = 2;
  logic [255:0] stub_res     = '0;
  vec_t         vt [4];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of one block.
  function automatic logic [255:0] sha(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7]  + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]    + f, hin[63:32]    + g, hin[31:0]     + hh};
  endfunction

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chkn(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // One cycle: sample outputs at negedge, score digests, then run the core stub.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (bus.digest_v) begin
      n_dv++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_digest_v: got digest %h required no pulse", bus.digest);
      end else begin
        e = sb.pop_front();
        chkv("digest", bus.digest, e.dg);
        chkn("blk_cnt", int'(bus.blk_cnt), int'(e.cnt));
      end
    end
    if (bus.core_out_v) bus.core_out_v = 1'b0;
    if (stub_pending) begin
      if (stub_cnt == 0) begin
        bus.core_out_v = 1'b1;
        bus.core_H_out = stub_res;
        stub_pending   = 1'b0;
      end else begin
        stub_cnt--;
      end
    end
    if (bus.core_in_v) begin
      n_req++;
      if (stub_pending) begin
        total++; bad++;
        $display("FAIL overlap_req: got request with result pending, required none");
      end
      req_h.push_back(bus.core_H_in);
      req_m.push_back(bus.core_M_in);
      stub_res = sha(bus.core_H_in, bus.core_M_in);
      res_h.push_back(stub_res);
      stub_pending = stub_en;
      stub_cnt     = stub_lat;
    end
  endtask

  task automatic send_block(input logic [511:0] b, input logic last);
    int g = 0;
    bus.msg_v    = 1'b1;
    bus.msg_blk  = b;
    bus.msg_last = last;
    while (bus.msg_rdy !== 1'b1 && g < 500) begin
      step();
      g++;
    end
    if (g >= 500) begin
      total++; bad++;
      $display("FAIL accept_wait: got msg_rdy=0 for 500 cycles required 1");
    end
    step();
    bus.msg_v = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      step();
      g++;
    end
    if (g >= 3000) begin
      total++; bad++;
      $display("FAIL digest_wait: got %0d outstanding digests required 0", sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chkv({tag, "_core_H_in"}, bus.core_H_in, '0);
    chkv({tag, "_core_M_in"}, bus.core_M_in[255:0] | bus.core_M_in[511:256], '0);
    chkb({tag, "_core_in_v"}, bus.core_in_v, 1'b0);
    chkv({tag, "_digest"},    bus.digest, '0);
    chkb({tag, "_digest_v"},  bus.digest_v, 1'b0);
    chkn({tag, "_blk_cnt"},   int'(bus.blk_cnt), 0);
    chkb({tag, "_err"},       bus.err, 1'b0);
    chkb({tag, "_msg_rdy"},   bus.msg_rdy, 1'b1);
    chkb({tag, "_busy"},      bus.busy, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           r;
    int           d;
    logic [255:0] hm;
    logic [511:0] bk;
    exp_t         e;

    bus.h_init = IV;  bus.msg_blk = '0;  bus.msg_v = 1'b0;  bus.msg_last = 1'b0;
    bus.abort  = 1'b0; bus.core_H_out = '0; bus.core_out_v = 1'b0;

    vt[0].nblk = 1; vt[0].blk[0] = BLK_ABC;   vt[0].blk[1] = '0;     vt[0].exp = DG_ABC;
    vt[1].nblk = 2; vt[1].blk[0] = BLK_2A;    vt[1].blk[1] = BLK_2B; vt[1].exp = DG_2;
    vt[2].nblk = 1; vt[2].blk[0] = BLK_EMPTY; vt[2].blk[1] = '0;     vt[2].exp = DG_EMPTY;
    vt[3].nblk = 1; vt[3].blk[0] = BLK_ABC;   vt[3].blk[1] = '0;     vt[3].exp = DG_ABC;

    repeat (3) step();
    check_reset_vals("por");
    reset = 1'b1;
    step();

    // Table-driven messages with random core latency.
    for (int i = 0; i < 4; i++) begin
      stub_lat = $urandom_range(0, 6);
      r = n_req;
      req_h.delete(); req_m.delete(); res_h.delete();
      e.dg = vt[i].exp; e.cnt = CNT_W'(vt[i].nblk);
      sb.push_back(e);
      for (int b = 0; b < vt[i].nblk; b++) begin
        send_block(vt[i].blk[b], b == vt[i].nblk - 1);
        chkb("issue_pulse", bus.core_in_v, 1'b1);
        chkb("rdy_low_busy", bus.msg_rdy, 1'b0);
      end
      wait_done();
      chkn("req_count", n_req - r, vt[i].nblk);
      chkv("first_H_in", req_h[0], IV);
      for (int b = 0; b < vt[i].nblk && b < req_m.size(); b++)
        chkv("M_in", req_m[b][255:0] ^ vt[i].blk[b][255:0], '0);
      if (vt[i].nblk == 2 && req_h.size() == 2) chkv("chain_H_in", req_h[1], res_h[0]);
    end

    // Counter saturation over a 257-block message.
    stub_lat = 0;
    hm = IV;
    for (int k = 0; k < 257; k++) hm = sha(hm, {32'(k), 480'h0});
    e.dg = hm; e.cnt = '1;
    sb.push_back(e);
    r = n_req;
    for (int k = 0; k < 257; k++) send_block({32'(k), 480'h0}, k == 256);
    wait_done();
    chkn("sat_req_count", n_req - r, 257);

    // Abort in WAIT during the first of two blocks.
    stub_lat = 15;
    d = n_dv;
    send_block(BLK_2A, 1'b0);
    step();
    chkb("abort_pre_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chkb("abort_busy", bus.busy, 1'b0);
    chkb("abort_rdy", bus.msg_rdy, 1'b1);
    chkn("abort_blk_cnt", int'(bus.blk_cnt), 0);
    repeat (25) step();
    chkn("abort_no_dv", n_dv - d, 0);
    stub_lat = 3;
    req_h.delete();
    e.dg = DG_ABC; e.cnt = 1;
    sb.push_back(e);
    send_block(BLK_ABC, 1'b1);
    wait_done();
    chkv("post_abort_H_in", req_h[0], IV);

    // Abort wins over a simultaneous acceptance.
    r = n_req;
    bus.abort = 1'b1; bus.msg_v = 1'b1; bus.msg_blk = BLK_ABC; bus.msg_last = 1'b1;
    step();
    bus.abort = 1'b0; bus.msg_v = 1'b0;
    chkb("abort_acc_busy", bus.busy, 1'b0);
    step();
    chkn("abort_acc_req", n_req - r, 0);

    // Abort wins over a simultaneous core_out_v.
    stub_lat = 4;
    d = n_dv;
    send_block(BLK_ABC, 1'b1);
    repeat (5) step();
    chkb("abort_outv_align", bus.core_out_v, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chkb("abort_outv_busy", bus.busy, 1'b0);
    chkn("abort_outv_blk_cnt", int'(bus.blk_cnt), 0);
    repeat (3) step();
    chkn("abort_outv_no_dv", n_dv - d, 0);

    // Reset mid-WAIT, then a late core_out_v.
    stub_lat = 10;
    d = n_dv;
    send_block(BLK_ABC, 1'b1);
    step();
    reset = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) step();
    reset = 1'b1;
    repeat (15) step();
    chkn("rst_no_dv", n_dv - d, 0);
    chkb("rst_idle", bus.busy, 1'b0);
    stub_lat = 1;
    e.dg = DG_ABC; e.cnt = 1;
    sb.push_back(e);
    send_block(BLK_ABC, 1'b1);
    wait_done();

`ifdef SHA_TIMEOUT_EN
    // Core never answers: err fires TMO cycles after entering WAIT.
    stub_en = 1'b0;
    d = n_dv;
    send_block(BLK_ABC, 1'b1);
    step();
    repeat (TMO - 1) step();
    chkb("tmo_pre_err", bus.err, 1'b0);
    chkb("tmo_pre_busy", bus.busy, 1'b1);
    step();
    chkb("tmo_err", bus.err, 1'b1);
    chkb("tmo_rdy", bus.msg_rdy, 1'b1);
    step();
    chkb("tmo_err_pulse", bus.err, 1'b0);
    chkn("tmo_no_dv", n_dv - d, 0);
    stub_en = 1'b1;
`else
    bk = BLK_ABC;
    d = n_dv;
    stub_en = 1'b0;
    send_block(bk, 1'b1);
    repeat (200) step();
    chkb("no_tmo_err", bus.err, 1'b0);
    chkb("no_tmo_busy", bus.busy, 1'b1);
    chkn("no_tmo_no_dv", n_dv - d, 0);
    stub_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
